riv_timeout_ctrl: RTL
=====================

// Module: riv_timeout_ctrl
// PURPOSE
//  Programmable timeout/retry supervisor: arms a prescaled down-count on start and ends the wait on ack.
//  On expiry with no ack it re-arms up to max_retry times, then flags fail.
//  Sits downstream of the small count primitives: consumes terminal-count events and drives link-level recovery control.
// PARAMETERS
//  TIMEOUT_W   16  width of timeout_val / main down-count
//  PRESCALE_W  8   width of prescale_val / tick divider
//  RETRY_W     3   width of max_retry / retry_cnt
// PORTS
//  clk           in   1           clock; single clock domain
//  rst           in   1           reset, asynchronous assert, active-high
//  start         in   1           arm request (IDLE or FAIL only)
//  abort         in   1           unconditional return to IDLE
//  ack           in   1           awaited event arrived; ends wait
//  timeout_val   in   TIMEOUT_W   ticks per attempt (T), captured on start
//  prescale_val  in   PRESCALE_W  tick = P+1 clk cycles, captured on start
//  max_retry     in   RETRY_W     re-arms allowed after first expiry (R), captured on start
//  busy          out  1           high while ARMED
//  timeout_pulse out  1           1-cycle pulse per expiry
//  done          out  1           1-cycle pulse when ack ends an ARMED wait
//  fail          out  1           high in FAIL
//  retry_cnt     out  RETRY_W     re-arms taken this run; held after ack/fail
// BEHAVIOUR
//  Reset: state=IDLE, busy/timeout_pulse/done/fail=0, retry_cnt=0, counters and captured config = 0.
//  All outputs registered. States: IDLE, ARMED, FAIL.
//  Priority per edge: abort > ack > expiry > tick > start.
//  IDLE/FAIL + start: capture T,P,R; cnt<=T, pre<=P, retry_cnt<=0, fail<=0, state<=ARMED.
//  ARMED, each edge:
//   - cnt==0: expiry. timeout_pulse<=1.
//     retry_cnt<R: retry_cnt++, cnt<=T, pre<=P, stay ARMED.
//     Otherwise: state<=FAIL, fail<=1.
//   - else pre==0: tick. pre<=P, cnt<=cnt-1.
//   - else pre<=pre-1.
//  Latency (start-sampling edge = edge 0): first timeout_pulse rises at edge T*(P+1)+1.
//  Each re-armed attempt adds T*(P+1)+1 edges.
//  T=0: expiry at edge 1 on every attempt. P=0: tick on every edge.
//  ack in ARMED: state<=IDLE, done<=1, no timeout_pulse, even if expiry falls on the same edge.
//  ack outside ARMED is ignored.
//  abort: any state -> IDLE; done/timeout_pulse stay 0; fail<=0; retry_cnt held.
//  start while ARMED is ignored (no restart). Config inputs may change freely after capture.
//  retry_cnt never wraps (bounded by R). R=0: first expiry goes straight to FAIL.
//  FAIL is sticky until start (re-arm) or abort (IDLE).
//  Reset mid-run: immediate return to reset values, with no pulse.
// STRUCTURE
//  riv_timeout_pkg: state_t enum {IDLE, ARMED, FAIL}; default width localparams.
//  Sub-module riv_tick_gen: PRESCALE_W down-counter with load/value/enable; emits tick when count==0 and enabled, then auto-reloads.
//  Top-level holds the FSM, main counter, retry counter and config capture registers.
// TESTING
//  T=3,P=1,R=0, start, no ack -> timeout_pulse at edge 7; fail=1 from edge 7; busy low.
//  T=2,P=0,R=2, no ack -> pulses at edges 3,6,9; retry_cnt 1,2 then FAIL with retry_cnt=2.
//  T=5,P=0, ack at edge 4 -> done pulse at edge 4; no timeout_pulse; retry_cnt=0; IDLE.
//  T=2,P=0, ack and expiry both at edge 3 -> done=1, timeout_pulse=0.
//  T=0 -> timeout_pulse at edge 1.
//  abort in ARMED -> IDLE next edge, no pulses. start in FAIL -> fail clears, re-arms.
//  rst asserted mid-ARMED -> all outputs 0 asynchronously; start after release behaves as from power-up.

Source files
------------

// File: rtl/riv_timeout_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riv_timeout_pkg
//   Shared types and default widths for the timeout/retry supervisor.
//   state_t     : supervisor FSM encoding (IDLE, ARMED, FAIL)
//   *_W_DEF     : default widths for timeout count, prescaler and retry count
// -----------------------------------------------------------------------------
package riv_timeout_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FAIL  = 2'd2
   } state_t;

   localparam int TIMEOUT_W_DEF  = 16;
   localparam int PRESCALE_W_DEF = 8;
   localparam int RETRY_W_DEF    = 3;

endpackage

// File: rtl/riv_timeout_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// riv_tick_gen
//   Prescaler down-counter. Emits one tick per (value+1) enabled cycles and
//   reloads itself from 'value' on the tick.
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   load     : force count <= value (takes priority over enable)
//   en       : count this cycle
//   value    : load / reload value (P)
//   tick     : count reached zero while enabled (combinational)
// -----------------------------------------------------------------------------
module riv_tick_gen
   import riv_timeout_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] value,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt_q;
   logic [PRESCALE_W-1:0] cnt_d;

   assign tick = en && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (tick) begin
         cnt_d = value;
      end else if (en) begin
         cnt_d = cnt_q - PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/riv_timeout_ctrl.sv
// -----------------------------------------------------------------------------
// riv_timeout_ctrl
//   Timeout/retry supervisor. 'start' arms a prescaled down-count of T ticks
//   (tick = P+1 clocks). 'ack' ends the wait with a done pulse. Each expiry
//   without ack pulses timeout_pulse and re-arms, up to R times, after which
//   the block sits in FAIL until start or abort.
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   start         : arm request (honoured in IDLE or FAIL only)
//   abort         : unconditional return to IDLE
//   ack           : awaited event arrived
//   timeout_val   : T, captured on start
//   prescale_val  : P, captured on start
//   max_retry     : R, captured on start
//   busy          : high while ARMED
//   timeout_pulse : one-cycle pulse per expiry
//   done          : one-cycle pulse when ack ends an ARMED wait
//   fail          : high while in FAIL
//   retry_cnt     : re-arms taken this run, held after ack/fail/abort
// -----------------------------------------------------------------------------
module riv_timeout_ctrl
   import riv_timeout_pkg::*;
#(
   parameter int TIMEOUT_W  = TIMEOUT_W_DEF,
   parameter int PRESCALE_W = PRESCALE_W_DEF,
   parameter int RETRY_W    = RETRY_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  ack,
   input  logic [TIMEOUT_W-1:0]  timeout_val,
   input  logic [PRESCALE_W-1:0] prescale_val,
   input  logic [RETRY_W-1:0]    max_retry,
   output logic                  busy,
   output logic                  timeout_pulse,
   output logic                  done,
   output logic                  fail,
   output logic [RETRY_W-1:0]    retry_cnt
);

   state_t                state_q, state_d;
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
   logic [TIMEOUT_W-1:0]  t_cfg_q, t_cfg_d;
   logic [PRESCALE_W-1:0] p_cfg_q, p_cfg_d;
   logic [RETRY_W-1:0]    r_cfg_q, r_cfg_d;
   logic [RETRY_W-1:0]    retry_q, retry_d;
   logic                  busy_q, busy_d;
   logic                  pulse_q, pulse_d;
   logic                  done_q, done_d;
   logic                  fail_q, fail_d;

   logic                  pre_load;
   logic                  pre_en;
   logic [PRESCALE_W-1:0] pre_val;
   logic                  tick;

   riv_tick_gen #(
      .PRESCALE_W (PRESCALE_W)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .load  (pre_load),
      .en    (pre_en),
      .value (pre_val),
      .tick  (tick)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      t_cfg_d  = t_cfg_q;
      p_cfg_d  = p_cfg_q;
      r_cfg_d  = r_cfg_q;
      retry_d  = retry_q;
      pulse_d  = 1'b0;
      done_d   = 1'b0;
      pre_load = 1'b0;
      pre_en   = 1'b0;
      pre_val  = p_cfg_q;

      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            ARMED: begin
               if (ack) begin
                  // ack beats an expiry landing on the same edge
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else if (cnt_q == '0) begin
                  pulse_d = 1'b1;
                  if (retry_q < r_cfg_q) begin
                     retry_d  = retry_q + RETRY_W'(1);
                     cnt_d    = t_cfg_q;
                     pre_load = 1'b1;
                  end else begin
                     state_d = FAIL;
                  end
               end else begin
                  // prescaler only runs while a non-zero count is pending
                  pre_en = 1'b1;
                  if (tick) begin
                     cnt_d = cnt_q - TIMEOUT_W'(1);
                  end
               end
            end
            default: begin
               if (start) begin
                  t_cfg_d  = timeout_val;
                  p_cfg_d  = prescale_val;
                  r_cfg_d  = max_retry;
                  cnt_d    = timeout_val;
                  pre_load = 1'b1;
                  pre_val  = prescale_val;
                  retry_d  = '0;
                  state_d  = ARMED;
               end
            end
         endcase
      end

      busy_d = (state_d == ARMED);
      fail_d = (state_d == FAIL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         t_cfg_q <= '0;
         p_cfg_q <= '0;
         r_cfg_q <= '0;
         retry_q <= '0;
         busy_q  <= 1'b0;
         pulse_q <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_cfg_q <= t_cfg_d;
         p_cfg_q <= p_cfg_d;
         r_cfg_q <= r_cfg_d;
         retry_q <= retry_d;
         busy_q  <= busy_d;
         pulse_q <= pulse_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
      end
   end

   assign busy          = busy_q;
   assign timeout_pulse = pulse_q;
   assign done          = done_q;
   assign fail          = fail_q;
   assign retry_cnt     = retry_q;

endmodule
